// File: rtl/conv_pkg.sv
//------------------------------------------------------------------------------
// conv_pkg : shared types and default sizes for the convolution control path
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } load_state_t;

    localparam int C_DEF_T                = 8;
    localparam int C_DEF_X_MEM_SIZE       = 8;
    localparam int C_DEF_F_MEM_SIZE       = 4;
    localparam int C_DEF_X_MEM_ADDR_WIDTH = 3;
    localparam int C_DEF_F_MEM_ADDR_WIDTH = 2;

endpackage : conv_pkg

`default_nettype wire

// File: rtl/wr_addr_cnt.sv
//------------------------------------------------------------------------------
// wr_addr_cnt : wrapping write-address counter with sticky full flag
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wr_addr_cnt #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(SIZE - 1);

    // wrap marks the increment that completes the set this cycle
    assign wrap = inc && (cnt == C_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            if (inc) begin
                cnt <= wrap ? '0 : cnt + WIDTH'(1);
            end
            // clear wins so a set completed on the RUN entry edge is not left full
            if (clr) begin
                full <= 1'b0;
            end else if (wrap) begin
                full <= 1'b1;
            end
        end
    end

endmodule : wr_addr_cnt

`default_nettype wire

// File: rtl/ctrl_input_load.sv
//------------------------------------------------------------------------------
// ctrl_input_load : loads x samples and f coefficients, then holds conv_start
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_input_load
    import conv_pkg::*;
#(
    parameter int T                = C_DEF_T,
    parameter int X_MEM_SIZE       = C_DEF_X_MEM_SIZE,
    parameter int F_MEM_SIZE       = C_DEF_F_MEM_SIZE,
    parameter int X_MEM_ADDR_WIDTH = C_DEF_X_MEM_ADDR_WIDTH,
    parameter int F_MEM_ADDR_WIDTH = C_DEF_F_MEM_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [T-1:0]                s_data_in_x,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic [T-1:0]                s_data_in_f,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    output logic                        xmem_wr_en,
    output logic [X_MEM_ADDR_WIDTH-1:0] xmem_wr_addr,
    output logic [T-1:0]                xmem_wr_data,
    output logic                        fmem_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] fmem_wr_addr,
    output logic [T-1:0]                fmem_wr_data,
    output logic                        conv_start,
    input  logic                        conv_done
);

    load_state_t                 r_state;
    load_state_t                 w_state_nxt;
    logic                        w_enter_run;
    logic [X_MEM_ADDR_WIDTH-1:0] w_x_cnt;
    logic [F_MEM_ADDR_WIDTH-1:0] w_f_cnt;
    logic                        w_x_full;
    logic                        w_f_full;
    logic                        w_x_wrap;
    logic                        w_f_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // a beat accepted on this very edge counts towards completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if ((w_x_full || w_x_wrap) && (w_f_full || w_f_wrap)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (conv_done) begin
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // readies are gated by the reset input so they drop the moment reset asserts
    always_comb begin
        s_ready_x  = reset && (r_state == LOAD) && !w_x_full;
        s_ready_f  = reset && (r_state == LOAD) && !w_f_full;
        conv_start = (r_state == RUN);
    end

    assign w_enter_run  = (r_state == LOAD) && (w_state_nxt == RUN);

    assign xmem_wr_en   = s_valid_x && s_ready_x;
    assign xmem_wr_addr = w_x_cnt;
    assign xmem_wr_data = s_data_in_x;

    assign fmem_wr_en   = s_valid_f && s_ready_f;
    assign fmem_wr_addr = w_f_cnt;
    assign fmem_wr_data = s_data_in_f;

    wr_addr_cnt #(
        .SIZE  (X_MEM_SIZE),
        .WIDTH (X_MEM_ADDR_WIDTH)
    ) u_x_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (xmem_wr_en),
        .clr   (w_enter_run),
        .cnt   (w_x_cnt),
        .full  (w_x_full),
        .wrap  (w_x_wrap)
    );

    wr_addr_cnt #(
        .SIZE  (F_MEM_SIZE),
        .WIDTH (F_MEM_ADDR_WIDTH)
    ) u_f_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fmem_wr_en),
        .clr   (w_enter_run),
        .cnt   (w_f_cnt),
        .full  (w_f_full),
        .wrap  (w_f_wrap)
    );

endmodule : ctrl_input_load

`default_nettype wire

// File: tb/tb_ctrl_input_load.sv
//------------------------------------------------------------------------------
// tb_ctrl_input_load : scoreboard bench for ctrl_input_load
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_input_load;

    localparam int XS  = 8;
    localparam int FS  = 4;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dx = '0;
    logic       vx = 1'b0;
    logic       s_ready_x;
    logic [7:0] df = '0;
    logic       vf = 1'b0;
    logic       s_ready_f;
    logic       xmem_wr_en;
    logic [2:0] xmem_wr_addr;
    logic [7:0] xmem_wr_data;
    logic       fmem_wr_en;
    logic [1:0] fmem_wr_addr;
    logic [7:0] fmem_wr_data;
    logic       conv_start;
    logic       conv_done = 1'b0;

    int checks   = 0;
    int failures = 0;

    int exp_x[$];
    int exp_f[$];
    int xa = 0;
    int fa = 0;

    // reference model: beats per data set and whether the set is being consumed
    int m_xc  = 0;
    int m_fc  = 0;
    bit m_run = 1'b0;

    ctrl_input_load dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (dx),
        .s_valid_x    (vx),
        .s_ready_x    (s_ready_x),
        .s_data_in_f  (df),
        .s_valid_f    (vf),
        .s_ready_f    (s_ready_f),
        .xmem_wr_en   (xmem_wr_en),
        .xmem_wr_addr (xmem_wr_addr),
        .xmem_wr_data (xmem_wr_data),
        .fmem_wr_en   (fmem_wr_en),
        .fmem_wr_addr (fmem_wr_addr),
        .fmem_wr_data (fmem_wr_data),
        .conv_start   (conv_start),
        .conv_done    (conv_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares every cycle against the model, pops expected writes
    always @(negedge clk) begin
        bit ax;
        bit af;
        int e;
        if (!reset) begin
            chk("rst_ready_x", int'(s_ready_x), 0);
            chk("rst_ready_f", int'(s_ready_f), 0);
            chk("rst_start", int'(conv_start), 0);
            chk("rst_wr_x", int'(xmem_wr_en), 0);
            chk("rst_wr_f", int'(fmem_wr_en), 0);
            m_xc = 0; m_fc = 0; m_run = 1'b0;
            exp_x.delete(); exp_f.delete();
        end else begin
            ax = vx && !m_run && (m_xc < XS);
            af = vf && !m_run && (m_fc < FS);
            chk("ready_x", int'(s_ready_x), int'(!m_run && (m_xc < XS)));
            chk("ready_f", int'(s_ready_f), int'(!m_run && (m_fc < FS)));
            chk("conv_start", int'(conv_start), int'(m_run));
            chk("wr_en_x", int'(xmem_wr_en), int'(ax));
            chk("wr_en_f", int'(fmem_wr_en), int'(af));
            if (xmem_wr_en) begin
                e = (exp_x.size() > 0) ? exp_x.pop_front() : -1;
                chk("x_addr_data", int'({xmem_wr_addr, xmem_wr_data}), e);
            end
            if (fmem_wr_en) begin
                e = (exp_f.size() > 0) ? exp_f.pop_front() : -1;
                chk("f_addr_data", int'({fmem_wr_addr, fmem_wr_data}), e);
            end
            if (ax) m_xc++;
            if (af) m_fc++;
            if (m_run) begin
                if (conv_done) m_run = 1'b0;
            end else if (m_xc == XS && m_fc == FS) begin
                m_run = 1'b1; m_xc = 0; m_fc = 0;
            end
        end
    end

    // all driver tasks start and end at posedge+1
    task automatic send_x(input logic [7:0] d, input int stall);
        bit acc = 1'b0;
        int n = 0;
        vx = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        exp_x.push_back((xa << 8) | int'(d));
        xa = (xa + 1) % XS;
        vx = 1'b1; dx = d;
        while (!acc && n < TMO) begin
            @(negedge clk); acc = s_ready_x;
            @(posedge clk); #1; n++;
        end
        vx = 1'b0;
        if (!acc) chk("x_accept_timeout", 0, 1);
    endtask

    task automatic send_f(input logic [7:0] d, input int stall);
        bit acc = 1'b0;
        int n = 0;
        vf = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        exp_f.push_back((fa << 8) | int'(d));
        fa = (fa + 1) % FS;
        vf = 1'b1; df = d;
        while (!acc && n < TMO) begin
            @(negedge clk); acc = s_ready_f;
            @(posedge clk); #1; n++;
        end
        vf = 1'b0;
        if (!acc) chk("f_accept_timeout", 0, 1);
    endtask

    task automatic pulse_done();
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk); seen = conv_start;
            @(posedge clk); #1; n++;
        end
        if (!seen) chk("start_timeout", 0, 1);
    endtask

    task automatic rand_set(input int maxstall);
        fork
            for (int i = 0; i < XS; i++) send_x(8'($urandom), int'($urandom_range(0, maxstall)));
            for (int i = 0; i < FS; i++) send_f(8'($urandom), int'($urandom_range(0, maxstall)));
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // directed load, no stalls
        fork
            for (int i = 1; i <= 8; i++) send_x(8'(i), 0);
            for (int i = 10; i <= 13; i++) send_f(8'(i), 0);
        join

        // valid held during RUN, released by conv_done
        fork
            send_x(8'h55, 0);
            send_f(8'h66, 0);
            begin repeat (10) begin @(posedge clk); #1; end pulse_done(); end
        join
        fork
            for (int i = 0; i < XS - 1; i++) send_x(8'($urandom), int'($urandom_range(0, 2)));
            for (int i = 0; i < FS - 1; i++) send_f(8'($urandom), int'($urandom_range(0, 2)));
        join
        wait_start();
        pulse_done();

        // randomly stalled interleaved sets
        for (int s = 0; s < 4; s++) begin
            rand_set(3);
            wait_start();
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            pulse_done();
        end

        // conv_done in LOAD is ignored
        fork
            begin
                for (int i = 0; i < 3; i++) send_x(8'($urandom), 0);
                pulse_done();
                for (int i = 3; i < XS; i++) send_x(8'($urandom), 1);
            end
            for (int i = 0; i < FS; i++) send_f(8'($urandom), 2);
        join
        wait_start();
        pulse_done();

        // asynchronous reset after a partial load
        fork
            for (int i = 0; i < 5; i++) send_x(8'($urandom), 0);
            for (int i = 0; i < 2; i++) send_f(8'($urandom), 0);
        join
        vx = 1'b1; vf = 1'b1;
        #1;
        chk("pre_rst_wr_x", int'(xmem_wr_en), 1);
        chk("pre_rst_wr_f", int'(fmem_wr_en), 1);
        reset = 1'b0;
        #1;
        chk("async_ready_x", int'(s_ready_x), 0);
        chk("async_ready_f", int'(s_ready_f), 0);
        chk("async_wr_x", int'(xmem_wr_en), 0);
        chk("async_wr_f", int'(fmem_wr_en), 0);
        vx = 1'b0; vf = 1'b0;
        xa = 0; fa = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        rand_set(1);
        wait_start();
        pulse_done();

        // last x and last f accepted on the same edge
        fork
            for (int i = 0; i < XS; i++) send_x(8'($urandom), 0);
            begin
                send_f(8'($urandom), XS - FS);
                for (int i = 1; i < FS; i++) send_f(8'($urandom), 0);
            end
        join
        wait_start();
        pulse_done();
        repeat (3) begin @(posedge clk); #1; end

        chk("x_queue_empty", exp_x.size(), 0);
        chk("f_queue_empty", exp_f.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ctrl_input_load

`default_nettype wire

// File: doc/ctrl_input_load.md
Name: ctrl_input_load

Overview:
- Input-side control stage that sits directly upstream of the convolution output controller.
- Accepts two AXI-stream-style inputs: x samples and f coefficients. Writes them into the x and f memories through write-address counters.
- Raises a level conv_start once both memories are fully loaded, and holds it until the downstream controller pulses conv_done.
- On conv_done it re-opens both input streams for the next data set.

Parameters:
- T, 8, data width of x and f samples.
- X_MEM_SIZE, 8, number of x entries per data set.
- F_MEM_SIZE, 4, number of f entries per data set.
- X_MEM_ADDR_WIDTH, 3, x memory address width; must satisfy 2**X_MEM_ADDR_WIDTH >= X_MEM_SIZE.
- F_MEM_ADDR_WIDTH, 2, f memory address width; must satisfy 2**F_MEM_ADDR_WIDTH >= F_MEM_SIZE.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- s_data_in_x  in  T  x sample
- s_valid_x  in  1  x sample valid
- s_ready_x  out  1  x sample accepted when s_valid_x && s_ready_x
- s_data_in_f  in  T  f coefficient
- s_valid_f  in  1  f coefficient valid
- s_ready_f  out  1  f coefficient accepted when s_valid_f && s_ready_f
- xmem_wr_en  out  1  x memory write enable
- xmem_wr_addr  out  X_MEM_ADDR_WIDTH  x memory write address
- xmem_wr_data  out  T  x memory write data
- fmem_wr_en  out  1  f memory write enable
- fmem_wr_addr  out  F_MEM_ADDR_WIDTH  f memory write address
- fmem_wr_data  out  T  f memory write data
- conv_start  out  1  level; both memories are loaded and the convolution may run
- conv_done  in  1  one-cycle pulse from the output controller; the data set is finished

Behaviour:
- Reset (reset==0, asynchronous):
  - state=LOAD; x_cnt=0, f_cnt=0; x_full=0, f_full=0; conv_start=0.
  - Outputs during reset: s_ready_x=0, s_ready_f=0, wr_en=0.
- States:
  - LOAD: streams open.
  - RUN: streams closed, conv_start=1.
- s_ready_x = (state==LOAD) && !x_full. s_ready_f = (state==LOAD) && !f_full. Both are combinational from registered state only, with no dependency on valid.
- Write path is combinational and zero-latency:
  - xmem_wr_en = s_valid_x && s_ready_x; xmem_wr_addr = x_cnt; xmem_wr_data = s_data_in_x.
  - The f path is identical, using f_cnt and s_data_in_f.
- Counters:
  - On an accepted x beat, x_cnt increments.
  - When the accepted beat is at x_cnt==X_MEM_SIZE-1, x_cnt wraps to 0 and x_full is set.
  - f_cnt / f_full behave the same with F_MEM_SIZE.
- The x and f streams are independent and may be accepted in the same cycle, in any order or interleaving.
- LOAD->RUN transition:
  - Taken at the clock edge where both streams are complete, counting a beat accepted in that same cycle.
  - conv_start rises one cycle after the final accepted beat, which is also the cycle after that beat's memory write.
  - Entering RUN clears x_full and f_full.
- RUN:
  - s_ready_x=s_ready_f=0 and no writes occur; the memories are stable for the whole convolution.
  - conv_start stays 1.
- RUN->LOAD transition:
  - Taken on conv_done==1 at a clock edge. conv_start=0 from the next cycle, and the readies reassert that same cycle.
- conv_done received in LOAD is ignored.
- Surplus beats: valid asserted while the corresponding stream is full or in RUN is not accepted and must be held by the source.
- Reset mid-operation discards partial loads: counters return to 0 and the next data set starts at address 0.
- Both memories are fully rewritten for every data set.
- Throughput: at most one beat per stream per cycle. With no stalls, minimum load time is max(X_MEM_SIZE, F_MEM_SIZE) cycles.

Decomposition:
- Shared package conv_pkg holds:
  - typedef enum logic {LOAD, RUN} load_state_t;
  - the default sizes as localparams, shared with the output controller.
- One natural sub-module: wr_addr_cnt. It is a parameterised (SIZE, WIDTH) wrap counter with an increment enable and a full flag, instantiated once for x and once for f.
- The same wr_addr_cnt form is reused by the convolution datapath.

Test Plan:
- Reset, then 8 x beats (values 1..8) and 4 f beats (10..13) with continuous valid:
  - Required: writes to x addrs 0..7 and f addrs 0..3 with matching data.
  - Required: s_ready_f falls after 4 beats; conv_start=1 exactly one cycle after the 8th x beat.
- Interleaved stalls (valid toggling randomly on both streams):
  - Required: write addresses strictly sequential and no duplicate writes.
  - Required: conv_start rises only after the last of the 12 beats.
- Valid held in RUN:
  - Required: readies stay 0 and there are zero writes until a conv_done pulse.
  - Required: after the pulse, conv_start=0, readies=1, and the next x beat is written to address 0.
- conv_done pulsed during LOAD after 3 x beats:
  - Required: ignored; the state and counters are unchanged.
- Reset asserted after 5 x and 2 f beats:
  - Required: outputs go inactive immediately (asynchronously).
  - Required: after release, the first x and f beats go to address 0.
- Last x and last f beat accepted in the same cycle:
  - Required: both writes occur and conv_start rises on the next cycle.
